mem_arbiter_rr: RTL and testbench

- N-requester arbiter that shares one physical-memory port among the L1 caches (I-cache, D-cache, and future prefetch or victim-buffer clients).
- Generalises the two-client L1 arbiter in three ways: parametrised requester count and bus widths; selectable fixed-priority or round-robin policy; full request/response muxing inside the block, so no external cache_sel mux is needed.
- Sits between the L1 caches and the L2 cache or physical memory.

---
 rtl/mem_arbiter_rr.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Purpose : shares one downstream memory port among NUM_REQ cache clients, fixed-priority or round-robin.
// Latency : request seen in IDLE at cycle t drives mem_read/mem_write at t+1; resp passes through combinationally.
// Backpr. : requesters hold their strobes until req_resp; losers simply wait, nothing is dropped or queued.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req_read/req_write    per-requester strobes (NUM_REQ bits)
//   req_address/req_wdata packed per-requester address / write line, slot i at [i*W +: W]
//   req_resp              per-requester completion pulse, only the owner sees mem_resp
//   req_rdata             read line broadcast to every requester (= mem_rdata)
//   mem_*                 downstream request/response port
//   grant                 one-hot owner while BUSY, zero otherwise
//   busy                  high while a transaction is outstanding downstream
module mem_arbiter_rr #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int RR_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_resp,
  output logic [LINE_WIDTH-1:0]         req_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [LINE_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_resp,
  input  logic [LINE_WIDTH-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [NUM_REQ-1:0] req_any;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [SUM_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               in_busy;

  assign req_any = req_read | req_write;
  assign in_busy = (state_q == ST_BUSY);

  // ---------------------------------------------------------------------
  // Winner selection. Only consumed in IDLE, so it is free-running.
  // ---------------------------------------------------------------------
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    if (RR_MODE != 0) begin
      // Scan ptr, ptr+1, ... wrapping; first requester found wins.
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, ptr_q} + SUM_W'(k);
        if (scan_idx >= SUM_W'(NUM_REQ)) begin
          scan_idx = scan_idx - SUM_W'(NUM_REQ);
        end
        if (!win_vld && req_any[scan_idx[IDX_W-1:0]]) begin
          win_vld = 1'b1;
          win_idx = scan_idx[IDX_W-1:0];
        end
      end
    end else begin
      // Fixed priority: lowest index wins.
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_vld && req_any[k]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(k);
        end
      end
    end
  end

  // Next round-robin pointer: the slot just after the owner, wrapping.
  assign ptr_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (win_vld)  state_d = ST_BUSY;
      ST_BUSY:    if (mem_resp) state_d = ST_RELEASE;
      // One dead cycle lets the served client drop its strobe before the
      // next arbitration, so it cannot be re-granted on a stale request.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Owner / grant / pointer registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && win_vld) begin
        owner_q <= win_idx;
        grant_q <= NUM_REQ'(1) << win_idx;
      end
      if (in_busy && mem_resp) begin
        grant_q <= '0;
        // Fixed mode keeps the pointer parked at zero.
        if (RR_MODE != 0) begin
          ptr_q <= ptr_next;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath muxing
  // ---------------------------------------------------------------------
  // Outside BUSY the downstream address/data default to slot 0.
  assign sel_idx = in_busy ? owner_q : '0;

  always_comb begin
    busy        = in_busy;
    grant       = in_busy ? grant_q : '0;
    // Strobes follow the owner live, so a client that drops its strobe
    // early (protocol violation) deasserts downstream but keeps the grant.
    mem_read    = in_busy & req_read[owner_q];
    mem_write   = in_busy & req_write[owner_q];
    mem_address = req_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    mem_wdata   = req_wdata[sel_idx*LINE_WIDTH +: LINE_WIDTH];
    req_resp    = (in_busy && mem_resp) ? grant_q : '0;
    req_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

  localparam logic [15:0] A0 = 16'h1000;
  localparam logic [15:0] A1 = 16'h1230;
  localparam logic [15:0] A2 = 16'h2220;
  localparam logic [15:0] A3 = 16'h3330;
  localparam logic [127:0] W0   = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] PAT  = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] RD0  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] RD1  = 128'hCAFE_F00D_0000_0001_8000_0000_FFFF_0000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-requester round-robin DUT ----------------
  logic         r_reset;
  logic [3:0]   r_rd, r_wr, r_resp, r_grant;
  logic [63:0]  r_addr;
  logic [511:0] r_wdata;
  logic [127:0] r_rdata, r_mwdata, r_mrdata;
  logic         r_mrd, r_mwr, r_mresp, r_busy;
  logic [15:0]  r_maddr;

  mem_arbiter_rr #(.NUM_REQ(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(r_reset),
    .req_read(r_rd), .req_write(r_wr), .req_address(r_addr), .req_wdata(r_wdata),
    .req_resp(r_resp), .req_rdata(r_rdata),
    .mem_read(r_mrd), .mem_write(r_mwr), .mem_address(r_maddr), .mem_wdata(r_mwdata),
    .mem_resp(r_mresp), .mem_rdata(r_mrdata),
    .grant(r_grant), .busy(r_busy)
  );

  // ---------------- 2-requester fixed-priority DUT ----------------
  logic         f_reset;
  logic [1:0]   f_rd, f_wr, f_resp, f_grant;
  logic [31:0]  f_addr;
  logic [255:0] f_wdata;
  logic [127:0] f_rdata, f_mwdata, f_mrdata;
  logic         f_mrd, f_mwr, f_mresp, f_busy;
  logic [15:0]  f_maddr;

  mem_arbiter_rr #(.NUM_REQ(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(0)) u_fp (
    .clk(clk), .reset(f_reset),
    .req_read(f_rd), .req_write(f_wr), .req_address(f_addr), .req_wdata(f_wdata),
    .req_resp(f_resp), .req_rdata(f_rdata),
    .mem_read(f_mrd), .mem_write(f_mwr), .mem_address(f_maddr), .mem_wdata(f_mwdata),
    .mem_resp(f_mresp), .mem_rdata(f_mrdata),
    .grant(f_grant), .busy(f_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct packed {
    logic        chk;
    logic        rst;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        mr;
    logic [3:0]  gnt;
    logic        bsy;
    logic        mrd;
    logic        mwr;
    logic [3:0]  resp;
    logic [15:0] addr;
  } vec_t;

  function automatic vec_t mk(logic c, logic rs, logic [3:0] rd, logic [3:0] wr, logic mr,
                              logic [3:0] g, logic b, logic mrd, logic mwr, logic [3:0] rp,
                              logic [15:0] a);
    vec_t v;
    v.chk = c; v.rst = rs; v.rd = rd; v.wr = wr; v.mr = mr;
    v.gnt = g; v.bsy = b; v.mrd = mrd; v.mwr = mwr; v.resp = rp; v.addr = a;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // chk rst  rd    wr   mr | gnt  bsy mrd mwr resp addr
    // reset, then idle state
    vecs.push_back(mk(0, 1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    // single requester 1 read, mem_resp on 4th busy cycle
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 4'h0, A1));
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 4'h0, A1));
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 4'h0, A1));
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 1, 4'h2, 1, 1, 0, 4'h2, A1));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0)); // RELEASE
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0)); // IDLE
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 4'h0, A0)); // mem_resp ignored in IDLE
    vecs.push_back(mk(1, 1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0)); // reset: pointer back to 0
    // round-robin fairness: all four request continuously -> 0,1,2,3,0
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 1, 4'h1, 1, 1, 0, 4'h1, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 0, 4'h2, A1));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 1, 4'h4, 1, 1, 0, 4'h4, A2));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 1, 4'h8, 1, 1, 0, 4'h8, A3));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 1, 4'h1, 1, 1, 0, 4'h1, A0)); // wrapped to 0
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    // back-to-back: requester 0 writes, requester 1 waits (pointer is 1)
    vecs.push_back(mk(1, 0, 4'h0, 4'h1, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h2, 4'h1, 0, 4'h1, 1, 0, 1, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h2, 4'h1, 1, 4'h1, 1, 0, 1, 4'h1, A0)); // k
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0)); // k+1 RELEASE
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0)); // k+2 IDLE
    vecs.push_back(mk(1, 0, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 4'h0, A1)); // k+3 grant to 1
    // reset mid-BUSY
    vecs.push_back(mk(1, 1, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 4'h0, A1));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 4'h0, A0)); // no req_resp
    // pointer is 0 after reset: requesters {0,1} -> 0 wins
    vecs.push_back(mk(1, 0, 4'h3, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h3, 4'h0, 0, 4'h1, 1, 1, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h3, 4'h0, 1, 4'h1, 1, 1, 0, 4'h1, A0));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, A0));

    // static inputs
    r_reset = 1'b1; r_rd = '0; r_wr = '0; r_mresp = 1'b0; r_mrdata = '0;
    r_addr  = {A3, A2, A1, A0};
    r_wdata = '0;
    r_wdata[0 +: 128] = W0;
    f_reset = 1'b1; f_rd = '0; f_wr = '0; f_mresp = 1'b0; f_mrdata = '0;
    f_addr  = {16'h0BBB, 16'h0AAA};
    f_wdata = '0;

    // ---------------- table-driven pass on the round-robin DUT ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      r_reset = vecs[i].rst;
      r_rd    = vecs[i].rd;
      r_wr    = vecs[i].wr;
      r_mresp = vecs[i].mr;
      #1;
      if (vecs[i].chk) begin
        chk("grant",       i, 128'(r_grant), 128'(vecs[i].gnt));
        chk("busy",        i, 128'(r_busy),  128'(vecs[i].bsy));
        chk("mem_read",    i, 128'(r_mrd),   128'(vecs[i].mrd));
        chk("mem_write",   i, 128'(r_mwr),   128'(vecs[i].mwr));
        chk("req_resp",    i, 128'(r_resp),  128'(vecs[i].resp));
        chk("mem_address", i, 128'(r_maddr), 128'(vecs[i].addr));
      end
    end

    // ---------------- data path + early strobe drop on requester 2 ----------------
    @(negedge clk);
    r_wr = 4'b0100; r_wdata[2*128 +: 128] = PAT; r_mrdata = RD0;
    #1;
    chk("rdata_idle", 0, r_rdata, RD0);
    chk("wdata_idle_slot0", 0, r_mwdata, W0);
    @(negedge clk);
    #1;
    chk("dp_grant", 0, 128'(r_grant), 128'(4'b0100));
    chk("dp_mem_write", 0, 128'(r_mwr), 128'd1);
    chk("dp_mem_wdata", 0, r_mwdata, PAT);
    chk("dp_mem_address", 0, 128'(r_maddr), 128'(A2));
    @(negedge clk);
    r_wr = 4'b0000; r_mrdata = RD1;
    #1;
    chk("drop_grant_held", 0, 128'(r_grant), 128'(4'b0100));
    chk("drop_busy_held", 0, 128'(r_busy), 128'd1);
    chk("drop_mem_write", 0, 128'(r_mwr), 128'd0);
    chk("rdata_busy", 0, r_rdata, RD1);
    @(negedge clk);
    r_mresp = 1'b1;
    #1;
    chk("drop_req_resp", 0, 128'(r_resp), 128'(4'b0100));
    @(negedge clk);
    r_mresp = 1'b0;
    #1;
    chk("drop_release_busy", 0, 128'(r_busy), 128'd0);
    chk("drop_release_grant", 0, 128'(r_grant), 128'd0);

    // ---------------- fixed priority: both request continuously ----------------
    @(negedge clk);
    f_reset = 1'b1;
    @(negedge clk);
    f_reset = 1'b0; f_rd = 2'b11;
    #1;
    chk("fp_idle_busy", 0, 128'(f_busy), 128'd0);
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        f_mresp = (c == 3);
        #1;
        chk("fp_grant", t*4 + c, 128'(f_grant), 128'(2'b01));
        chk("fp_mem_address", t*4 + c, 128'(f_maddr), 128'(16'h0AAA));
        if (c == 3) chk("fp_req_resp", t, 128'(f_resp), 128'(2'b01));
      end
      @(negedge clk);
      f_mresp = 1'b0;
      #1;
      chk("fp_release_grant", t, 128'(f_grant), 128'd0);
      @(negedge clk);
      #1;
      chk("fp_idle_busy", t + 1, 128'(f_busy), 128'd0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
